// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready producers.
// A grant lasts up to BURST beats and stalls on fifo_full. Arbitration takes 1 cycle from IDLE; re-grants from HOLD add no bubble.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int DT_WIDTH  = 8,
  parameter int BURST     = 4,
  parameter int SRC_WIDTH = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req_valid,
  input  logic [N*DT_WIDTH-1:0]   req_data,
  output logic [N-1:0]            req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wrt_en,
  output logic [DT_WIDTH-1:0]     fifo_wrt_dt,
  output logic [SRC_WIDTH-1:0]    fifo_wrt_src,
  output logic [SRC_WIDTH-1:0]    grant_id,
  output logic                    busy
);

  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0]        LAST_BEAT = CW'(BURST - 1);
  localparam logic [SRC_WIDTH-1:0] LAST_INIT = SRC_WIDTH'(N - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state, state_nxt;
  logic [SRC_WIDTH-1:0] last_id, last_nxt, grant_nxt;
  logic [CW-1:0]        beat_cnt, cnt_nxt;
  logic [SRC_WIDTH-1:0] pick, cand;
  logic                 any_valid, found, xfer, release_now;
  logic [DT_WIDTH-1:0]  req_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign req_arr[g] = req_data[g*DT_WIDTH +: DT_WIDTH];
  end

  assign any_valid = |req_valid;
  assign xfer      = (state == HOLD) && req_valid[grant_id] && !fifo_full;

  // Scanning from last_id+1 naturally puts the current holder last, so a lone
  // requester is re-picked while any other valid requester wins first.
  always_comb begin
    pick  = last_id;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = SRC_WIDTH'((int'(last_id) + k) % N);
      if (!found && req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      last_id  <= LAST_INIT;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      last_id  <= last_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_id;
    last_nxt    = last_id;
    cnt_nxt     = beat_cnt;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = HOLD;
          grant_nxt = pick;
          last_nxt  = pick;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        release_now = (xfer && beat_cnt == LAST_BEAT) || !req_valid[grant_id];
        if (release_now) begin
          if (any_valid) begin
            grant_nxt = pick;
            last_nxt  = pick;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (xfer) begin
          cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    busy         = (state == HOLD);
    fifo_wrt_en  = xfer;
    fifo_wrt_dt  = '0;
    fifo_wrt_src = '0;
    if (state == HOLD) begin
      req_ready[grant_id] = !fifo_full;
    end
    if (xfer) begin
      fifo_wrt_dt  = req_arr[grant_id];
      fifo_wrt_src = grant_id;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle table plus scoreboarded multi-cycle scenarios.
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, BURST = 4, SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wrt_en;
  logic [DW-1:0]   fifo_wrt_dt;
  logic [SW-1:0]   fifo_wrt_src;
  logic [SW-1:0]   grant_id;
  logic            busy;

  logic [DW-1:0]   pdata [N];

  fifo_wr_arbiter #(.N(N), .DT_WIDTH(DW), .BURST(BURST), .SRC_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wrt_en(fifo_wrt_en),
    .fifo_wrt_dt(fifo_wrt_dt), .fifo_wrt_src(fifo_wrt_src),
    .grant_id(grant_id), .busy(busy)
  );

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_data[g*DW +: DW] = pdata[g];
  end

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] src;
    logic [DW-1:0] dat;
  } exp_t;

  typedef struct {
    logic [N-1:0]  rv;
    logic          full;
    logic          busy;
    logic [SW-1:0] grant;
    logic [N-1:0]  ready;
    logic          wr;
    logic [SW-1:0] src;
  } vec_t;

  exp_t sb[$];
  vec_t vt[15];
  int checks = 0;
  int failures = 0;
  logic          s_busy, s_wr;
  logic [SW-1:0] s_grant;
  logic [N-1:0]  s_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic push(input int s, input logic [DW-1:0] d);
    exp_t e;
    e.src = SW'(s);
    e.dat = d;
    sb.push_back(e);
  endtask

  // Sample at negedge, score any write, then advance producers that handshook.
  task automatic tick();
    exp_t e;
    logic [N-1:0] hs;
    @(negedge clk);
    s_busy  = busy;
    s_wr    = fifo_wrt_en;
    s_grant = grant_id;
    s_ready = req_ready;
    if (fifo_wrt_en) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got src %0d dat %0h expected no write", fifo_wrt_src, fifo_wrt_dt);
      end else begin
        e = sb.pop_front();
        chk("wr_src", 32'(fifo_wrt_src), 32'(e.src));
        chk("wr_dat", 32'(fifo_wrt_dt), 32'(e.dat));
      end
    end else begin
      chk("nowr_dat_zero", 32'(fifo_wrt_dt), 0);
      chk("nowr_src_zero", 32'(fifo_wrt_src), 0);
    end
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) pdata[i] = pdata[i] + 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_en", 32'(fifo_wrt_en), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_dt", 32'(fifo_wrt_dt), 0);
    chk("rst_src", 32'(fifo_wrt_src), 0);
    chk("rst_grant", 32'(grant_id), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt [N];
    int s;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    rst = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;

    //           rv       full busy grant ready    wr  src
    vt[0]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    vt[1]  = '{4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    vt[2]  = '{4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 2'd1};
    vt[3]  = '{4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0};
    vt[4]  = '{4'b0110, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 2'd1};
    vt[5]  = '{4'b0100, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 2'd0};
    vt[6]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 2'd2};
    vt[7]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 2'd0};
    vt[8]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    vt[9]  = '{4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    vt[10] = '{4'b1001, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 2'd3};
    vt[11] = '{4'b0001, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 2'd0};
    vt[12] = '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 2'd0};
    vt[13] = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 2'd0};
    vt[14] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};

    // Cycle table: full stall, valid drop, wrap from 3 to 0, return to idle.
    do_reset();
    for (int i = 0; i < N; i++) pdata[i] = DW'(8'h50 + 8'h10 * i);
    for (int r = 0; r < 15; r++) begin
      req_valid = vt[r].rv;
      fifo_full = vt[r].full;
      if (vt[r].wr) push(int'(vt[r].src), pdata[vt[r].src]);
      tick();
      chk($sformatf("tbl%0d_busy", r), 32'(s_busy), 32'(vt[r].busy));
      chk($sformatf("tbl%0d_ready", r), 32'(s_ready), 32'(vt[r].ready));
      chk($sformatf("tbl%0d_wr", r), 32'(s_wr), 32'(vt[r].wr));
      if (vt[r].busy) chk($sformatf("tbl%0d_grant", r), 32'(s_grant), 32'(vt[r].grant));
    end
    chk("tbl_sb_empty", 32'(sb.size()), 0);

    // All requesters valid: strict rotation 0,1,2,3,0 with BURST beats each, no bubbles.
    do_reset();
    for (int i = 0; i < N; i++) begin
      pdata[i] = DW'(8'h40 * i);
      cnt[i] = 0;
    end
    for (int k = 0; k < 20; k++) begin
      s = (k / BURST) % N;
      push(s, DW'(int'(pdata[s]) + cnt[s]));
      cnt[s]++;
    end
    req_valid = '1;
    tick();
    chk("rr_first_idle_busy", 32'(s_busy), 0);
    chk("rr_first_idle_wr", 32'(s_wr), 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("rr_beat%0d_wr", k), 32'(s_wr), 1);
      chk($sformatf("rr_beat%0d_grant", k), 32'(s_grant), 32'((k / BURST) % N));
    end
    req_valid = '0;
    tick();
    chk("rr_sb_empty", 32'(sb.size()), 0);

    // Lone requester 2 streams across burst boundaries without a gap.
    do_reset();
    pdata[2] = 8'h10;
    for (int k = 0; k < 8; k++) push(2, DW'(8'h10 + k));
    req_valid = 4'b0100;
    tick();
    chk("solo_first_wr", 32'(s_wr), 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("solo_beat%0d_wr", k), 32'(s_wr), 1);
    end
    req_valid = '0;
    tick();
    chk("solo_sb_empty", 32'(sb.size()), 0);

    // FIFO full for 3 cycles after beat 2 of requester 1, then hand-off to 2.
    do_reset();
    pdata[1] = 8'h20;
    pdata[2] = 8'h30;
    for (int k = 0; k < 4; k++) push(1, DW'(8'h20 + k));
    push(2, 8'h30);
    req_valid = 4'b0010;
    tick();
    tick();
    tick();
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("full%0d_ready1", k), 32'(s_ready[1]), 0);
      chk($sformatf("full%0d_wr", k), 32'(s_wr), 0);
      chk($sformatf("full%0d_grant", k), 32'(s_grant), 1);
      chk($sformatf("full%0d_busy", k), 32'(s_busy), 1);
    end
    fifo_full = 1'b0;
    tick();
    chk("full_beat3_wr", 32'(s_wr), 1);
    req_valid = 4'b0110;
    tick();
    chk("full_beat4_wr", 32'(s_wr), 1);
    tick();
    chk("full_regrant", 32'(s_grant), 2);
    chk("full_regrant_wr", 32'(s_wr), 1);
    req_valid = '0;
    tick();
    tick();
    chk("full_sb_empty", 32'(sb.size()), 0);

    // Reset mid-burst: outputs drop at once, then requester 0 wins first.
    do_reset();
    pdata[0] = 8'h60;
    pdata[1] = 8'h70;
    push(1, 8'h70);
    req_valid = 4'b0010;
    tick();
    tick();
    chk("midrst_pre_wr", 32'(fifo_wrt_en), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(fifo_wrt_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(req_ready), 0);
    req_valid = 4'b0011;
    #1 rst = 1'b0;
    push(0, 8'h60);
    tick();
    chk("midrst_idle_wr", 32'(s_wr), 0);
    tick();
    chk("midrst_grant0", 32'(s_grant), 0);
    chk("midrst_busy_after", 32'(s_busy), 1);
    req_valid = '0;
    tick();
    chk("midrst_sb_empty", 32'(sb.size()), 0);

    // Quiet inputs keep the arbiter idle.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("quiet%0d_busy", k), 32'(s_busy), 0);
      chk($sformatf("quiet%0d_ready", k), 32'(s_ready), 0);
      chk($sformatf("quiet%0d_wr", k), 32'(s_wr), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of a syncfifo instance between N producers.
- Each producer has a valid/ready handshake.
- A grant is held for up to BURST beats, and writes stall cleanly on FIFO full.
- The arbiter drives the FIFO write enable/data and tags each beat with the source index for downstream debug and accounting.

Parameters:
- N, 4, number of requesters (2..8)
- DT_WIDTH, 8, data width; matches the FIFO DT_WIDTH
- BURST, 4, maximum beats per grant before forced re-arbitration (>=1)
- SRC_WIDTH, $clog2(N), width of the source index

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  N  per-requester data valid
- req_data  input  N*DT_WIDTH  requester i data at [i*DT_WIDTH +: DT_WIDTH]
- req_ready  output  N  per-requester accept; a beat transfers when valid&ready
- fifo_full  input  1  full flag from the FIFO
- fifo_wrt_en  output  1  FIFO write enable
- fifo_wrt_dt  output  DT_WIDTH  FIFO write data
- fifo_wrt_src  output  SRC_WIDTH  index of the requester whose beat is being written
- grant_id  output  SRC_WIDTH  currently granted requester (valid when busy=1)
- busy  output  1  grant active (state HOLD)

Behaviour:
- States: IDLE, HOLD. Registers: state, grant_id, last_id, beat_cnt ($clog2(BURST)+1 bits).
- Reset (async):
  - state=IDLE, grant_id=0, last_id=N-1, beat_cnt=0.
  - All outputs 0: req_ready=0, fifo_wrt_en=0, fifo_wrt_dt=0, fifo_wrt_src=0, busy=0.
  - Effect: requester 0 has top priority after reset.
- Round-robin pick:
  - Scan indices last_id+1, last_id+2, … modulo N; pick the first with req_valid=1.
  - The pick is combinational from the current req_valid and registered last_id.
- IDLE:
  - If any req_valid=1: next state HOLD, grant_id=pick, last_id=pick, beat_cnt=0.
  - Otherwise stay in IDLE.
  - No transfer occurs in IDLE: req_ready=0, so arbitration latency is 1 cycle.
- HOLD, outputs are combinational from the registers:
  - req_ready[grant_id] = !fifo_full; all other req_ready bits = 0.
  - xfer = req_valid[grant_id] & !fifo_full.
  - fifo_wrt_en = xfer.
  - fifo_wrt_dt = req_data slice of grant_id; fifo_wrt_src = grant_id.
  - Both are driven 0 when xfer=0.
  - busy=1.
- HOLD, release conditions (evaluated per cycle):
  - (a) xfer=1 and beat_cnt==BURST-1, i.e. burst exhausted.
  - (b) req_valid[grant_id]=0, i.e. the requester dropped; no transfer that cycle.
- HOLD, release action:
  - If any req_valid=1, with the released requester's own valid treated as 0 for case (a) only when another requester is valid: re-grant directly from HOLD to the pick, beat_cnt=0. There is no idle bubble.
  - Otherwise go to IDLE.
  - A lone requester that exhausts its burst is re-granted immediately and loses no cycle.
- HOLD, no release: beat_cnt increments on xfer; it holds while fifo_full=1.
- fifo_full mid-burst:
  - Grant is held indefinitely; there is no timeout and no beat is counted.
  - Data must be held stable by the requester (valid/ready rules).
- Handshake rule: requesters must not drop valid without a transfer. The arbiter tolerates it via release (b), but the beat is then not written.
- Simultaneous valid on all N: the service order is strictly rotating, with each requester getting ≤BURST beats per turn.
- Width rule: beat_cnt compares against BURST-1 at full width. No wrap occurs, because the counter is reset on every grant.
- Reset asserted mid-burst:
  - All state is cleared immediately; fifo_wrt_en drops asynchronously.
  - The partially transferred burst is not replayed.

Test Plan:
- Reset with N=4, BURST=4 and all req_valid=1 -> 1 cycle later busy=1, grant_id=0; 4 writes with fifo_wrt_src=0; then grant_id=1 with no bubble cycle; order 0,1,2,3,0.
- Only req 2 valid, continuous data 0x10,0x11,… -> first write 1 cycle after valid. Writes every cycle, including across burst boundaries (re-grant to 2). Sequence 0x10..0x17 in 8 consecutive cycles.
- Req 1 granted, fifo_full=1 asserted after beat 2 for 3 cycles -> req_ready[1]=0 and fifo_wrt_en=0 for those 3 cycles. Grant is held; beats 3..4 complete after full drops; then re-arbitration.
- Req 3 drops valid after 1 beat while req 0 valid -> next cycle grant_id=0 (wrap from 3 to 0); req 3 gets exactly 1 write.
- rst pulsed during beat 2 of a req 1 burst -> fifo_wrt_en=0 and busy=0 immediately. After release, the first grant goes to req 0 when reqs 0 and 1 are both valid.
- No requests for 10 cycles -> state IDLE, req_ready=0, fifo_wrt_en=0 throughout.
